// File: rtl/vram_scan_arbiter_if.sv
// rtl/vram_scan_arbiter_if.sv - sync-in, pixel write, RAM and video-out bundle for vram_scan_arbiter
// Clear-sweep signals exist only when VRAM_CLEAR_EN is defined.
interface vram_scan_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic [9:0]        hcount;
  logic [9:0]        vcount;
  logic              video_enable;
  logic              hsync_in;
  logic              vsync_in;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] pixel_out;
  logic              de_out;
  logic              hsync_out;
  logic              vsync_out;
`ifdef VRAM_CLEAR_EN
  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;
`endif

  modport master (
`ifdef VRAM_CLEAR_EN
    output clr_start, clr_color,
    input  clr_busy,
`endif
    output hcount, vcount, video_enable, hsync_in, vsync_in,
    output wr_valid, wr_addr, wr_data, ram_rdata,
    input  wr_ready, ram_addr, ram_we, ram_wdata,
    input  pixel_out, de_out, hsync_out, vsync_out
  );

  modport slave (
`ifdef VRAM_CLEAR_EN
    input  clr_start, clr_color,
    output clr_busy,
`endif
    input  hcount, vcount, video_enable, hsync_in, vsync_in,
    input  wr_valid, wr_addr, wr_data, ram_rdata,
    output wr_ready, ram_addr, ram_we, ram_wdata,
    output pixel_out, de_out, hsync_out, vsync_out
  );
endinterface

// File: rtl/vram_scan_arbiter.sv
// rtl/vram_scan_arbiter.sv - shares one framebuffer RAM between scan-out reads and FIFO-buffered pixel writes
// Optional VRAM_CLEAR_EN adds a clear sweep that fills the framebuffer with clr_color in free slots.
module vram_scan_arbiter #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input logic                clk_25MHz,
  input logic                reset,
  vram_scan_arbiter_if.slave bus
);
  localparam int S     = SCALE_SHIFT;
  localparam int FB_W  = H_RES >> S;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EW    = ADDR_W + DATA_W;
`ifdef VRAM_CLEAR_EN
  localparam int FB_SIZE = FB_W * (V_RES >> S);
`endif

  logic [EW-1:0]     fifo_mem_q [FIFO_DEPTH];
  logic [EW-1:0]     fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              rd_issue_q, rd_issue_d, rd_return_q, rd_return_d;
  logic [DATA_W-1:0] pixel_q, pixel_d, pixel_cur;
  logic              de1_q, de1_d, de_q, de_d;
  logic              hs1_q, hs1_d, hs_q, hs_d;
  logic              vs1_q, vs1_d, vs_q, vs_d;
`ifdef VRAM_CLEAR_EN
  logic              clr_busy_q, clr_busy_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] clr_color_q, clr_color_d;
`endif

  logic [ADDR_W:0]   scan_wide;
  logic              read_slot, fifo_empty, fifo_full, push, pop, store, fifo_pop;
  logic [EW-1:0]     head;

  always_comb begin
    scan_wide  = (ADDR_W+1)'(bus.vcount >> S) * (ADDR_W+1)'(FB_W) + (ADDR_W+1)'(bus.hcount >> S);
    // The vcount guard only matters if the sync generator ever raises enable off-screen.
    read_slot  = bus.video_enable && (bus.hcount[S-1:0] == '0) && (bus.vcount < 10'(V_RES));
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    push       = bus.wr_valid && !fifo_full;
    // An empty FIFO lets the incoming write fall straight through to the RAM.
    head       = fifo_empty ? {bus.wr_addr, bus.wr_data} : fifo_mem_q[rd_ptr_q];
    pop        = !read_slot && (!fifo_empty || push);
`ifdef VRAM_CLEAR_EN
    pop        = pop && !clr_busy_q;
`endif
    fifo_pop   = pop && !fifo_empty;
    store      = push && !(pop && fifo_empty);

    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
`ifdef VRAM_CLEAR_EN
    clr_busy_d  = clr_busy_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    if (!clr_busy_q && bus.clr_start) begin
      clr_busy_d  = 1'b1;
      clr_cnt_d   = '0;
      clr_color_d = bus.clr_color;
    end
`endif

    if (read_slot) begin
      ram_addr_d = scan_wide[ADDR_W-1:0];
`ifdef VRAM_CLEAR_EN
    end else if (clr_busy_q) begin
      ram_we_d    = 1'b1;
      ram_addr_d  = clr_cnt_q;
      ram_wdata_d = clr_color_q;
      if (clr_cnt_q == ADDR_W'(FB_SIZE - 1)) clr_busy_d = 1'b0;
      else                                   clr_cnt_d  = clr_cnt_q + 1'b1;
`endif
    end else if (pop) begin
      ram_we_d    = 1'b1;
      ram_addr_d  = head[EW-1:DATA_W];
      ram_wdata_d = head[DATA_W-1:0];
    end

    if (store) begin
      fifo_mem_d[wr_ptr_q] = {bus.wr_addr, bus.wr_data};
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (fifo_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({store, fifo_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    rd_issue_d  = read_slot;
    rd_return_d = rd_issue_q;
    pixel_cur   = rd_return_q ? bus.ram_rdata : pixel_q;
    pixel_d     = pixel_cur;
    de1_d       = bus.video_enable;
    de_d        = de1_q;
    hs1_d       = bus.hsync_in;
    hs_d        = hs1_q;
    vs1_d       = bus.vsync_in;
    vs_d        = vs1_q;
  end

  always_ff @(posedge clk_25MHz) begin
    fifo_mem_q <= fifo_mem_d;
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      rd_issue_q  <= 1'b0;
      rd_return_q <= 1'b0;
      pixel_q     <= '0;
      de1_q       <= 1'b0;
      de_q        <= 1'b0;
      hs1_q       <= 1'b1;
      hs_q        <= 1'b1;
      vs1_q       <= 1'b1;
      vs_q        <= 1'b1;
`ifdef VRAM_CLEAR_EN
      clr_busy_q  <= 1'b0;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      rd_issue_q  <= rd_issue_d;
      rd_return_q <= rd_return_d;
      pixel_q     <= pixel_d;
      de1_q       <= de1_d;
      de_q        <= de_d;
      hs1_q       <= hs1_d;
      hs_q        <= hs_d;
      vs1_q       <= vs1_d;
      vs_q        <= vs_d;
`ifdef VRAM_CLEAR_EN
      clr_busy_q  <= clr_busy_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_color_q <= clr_color_d;
`endif
    end
  end

  assign bus.wr_ready  = !fifo_full;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.pixel_out = de_q ? pixel_cur : '0;
  assign bus.de_out    = de_q;
  assign bus.hsync_out = hs_q;
  assign bus.vsync_out = vs_q;
`ifdef VRAM_CLEAR_EN
  assign bus.clr_busy  = clr_busy_q;
`endif
endmodule

// File: tb/tb_vram_scan_arbiter.sv
// tb/tb_vram_scan_arbiter.sv - directed vector bench for vram_scan_arbiter with a behavioural sync RAM
module tb_vram_scan_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  vram_scan_arbiter_if #(.ADDR_W(15), .DATA_W(8)) bus ();
  vram_scan_arbiter dut (.clk_25MHz(clk), .reset(reset), .bus(bus));

  logic [7:0] vram [32768];
  logic [7:0] rdata_q;
  always @(posedge clk) begin
    if (bus.ram_we) vram[bus.ram_addr] <= bus.ram_wdata;
    rdata_q <= vram[bus.ram_addr];
  end
  assign bus.ram_rdata = rdata_q;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        ven;
    logic        wv;
    logic [14:0] wa;
    logic [7:0]  wd;
    logic        e_we;
    logic [14:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_ready;
  } vec_t;

  vec_t vecs [12];
  logic [22:0] exp_q [$];
  logic [22:0] got_q [$];
  logic was_read;
  int c;
  int n;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input int hc, input int vc, input logic ven, input logic hs, input logic vs,
                       input logic wv, input logic [14:0] wa, input logic [7:0] wd);
    bus.hcount       = 10'(hc);
    bus.vcount       = 10'(vc);
    bus.video_enable = ven;
    bus.hsync_in     = hs;
    bus.vsync_in     = vs;
    bus.wr_valid     = wv;
    bus.wr_addr      = wa;
    bus.wr_data      = wd;
  endtask

  initial begin
    vecs[0]  = '{10'd700, 10'd500, 1'b0, 1'b1, 15'd5,     8'hA5, 1'b1, 15'd5,     8'hA5, 1'b1};
    vecs[1]  = '{10'd701, 10'd500, 1'b0, 1'b0, 15'd0,     8'h00, 1'b0, 15'd5,     8'h00, 1'b1};
    vecs[2]  = '{10'd702, 10'd500, 1'b0, 1'b1, 15'd19199, 8'h3C, 1'b1, 15'd19199, 8'h3C, 1'b1};
    vecs[3]  = '{10'd703, 10'd500, 1'b0, 1'b1, 15'd19198, 8'h11, 1'b1, 15'd19198, 8'h11, 1'b1};
    vecs[4]  = '{10'd704, 10'd500, 1'b0, 1'b1, 15'd20000, 8'hFF, 1'b1, 15'd20000, 8'hFF, 1'b1};
    vecs[5]  = '{10'd0,   10'd0,   1'b1, 1'b1, 15'd7,     8'h22, 1'b0, 15'd0,     8'h00, 1'b1};
    vecs[6]  = '{10'd1,   10'd0,   1'b1, 1'b0, 15'd0,     8'h00, 1'b1, 15'd7,     8'h22, 1'b1};
    vecs[7]  = '{10'd8,   10'd4,   1'b1, 1'b0, 15'd0,     8'h00, 1'b0, 15'd162,   8'h00, 1'b1};
    vecs[8]  = '{10'd639, 10'd8,   1'b1, 1'b0, 15'd0,     8'h00, 1'b0, 15'd162,   8'h00, 1'b1};
    vecs[9]  = '{10'd636, 10'd479, 1'b1, 1'b0, 15'd0,     8'h00, 1'b0, 15'd19199, 8'h00, 1'b1};
    vecs[10] = '{10'd636, 10'd479, 1'b0, 1'b0, 15'd0,     8'h00, 1'b0, 15'd19199, 8'h00, 1'b1};
    vecs[11] = '{10'd4,   10'd7,   1'b1, 1'b0, 15'd0,     8'h00, 1'b0, 15'd161,   8'h00, 1'b1};

    drive(700, 500, 1'b0, 1'b0, 1'b0, 1'b0, 15'd0, 8'h00);
`ifdef VRAM_CLEAR_EN
    bus.clr_start = 1'b0;
    bus.clr_color = 8'h00;
`endif
    reset = 1'b1;
    tick();
    tick();
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wdata", bus.ram_wdata, 0);
    chk("rst_pixel_out", bus.pixel_out, 0);
    chk("rst_de_out", bus.de_out, 0);
    chk("rst_hsync_out", bus.hsync_out, 1);
    chk("rst_vsync_out", bus.vsync_out, 1);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(int'(vecs[i].hc), int'(vecs[i].vc), vecs[i].ven, 1'b1, 1'b1, vecs[i].wv, vecs[i].wa, vecs[i].wd);
      tick();
      chk($sformatf("vec%0d_we", i), bus.ram_we, vecs[i].e_we);
      chk($sformatf("vec%0d_addr", i), bus.ram_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_ready", i), bus.wr_ready, vecs[i].e_ready);
      if (vecs[i].e_we) chk($sformatf("vec%0d_wdata", i), bus.ram_wdata, vecs[i].e_wdata);
    end

    // Last visible line: 19198 and 19199 repeat 4 cycles each, then blanking output and sync delay.
    for (int hc = 630; hc <= 660; hc++) begin
      drive(hc, 479, hc < 640, hc < 656, hc < 652, 1'b0, 15'd0, 8'h00);
      tick();
      c = hc + 1;
      if (c == 637) chk("read_addr_19199", bus.ram_addr, 19199);
      if (c >= 634) begin
        chk($sformatf("pix_c%0d", c), bus.pixel_out, (c <= 637) ? 8'h11 : (c <= 641) ? 8'h3C : 8'h00);
        chk($sformatf("de_c%0d", c), bus.de_out, c <= 641);
        chk($sformatf("hs_c%0d", c), bus.hsync_out, c < 658);
        chk($sformatf("vs_c%0d", c), bus.vsync_out, c < 654);
      end
    end

    // Continuous pushes in active video: FIFO fills at hc28, push at hc29 must be refused.
    for (int hc = 0; hc <= 50; hc++) begin
      drive(hc, 10, 1'b1, 1'b1, 1'b1, hc <= 29, 15'(100 + hc), 8'(hc + 1));
      if (hc <= 28) exp_q.push_back({15'(100 + hc), 8'(hc + 1)});
      was_read = (hc % 4 == 0);
      tick();
      if (bus.ram_we) got_q.push_back({bus.ram_addr, bus.ram_wdata});
      if (was_read) chk($sformatf("no_we_after_read_hc%0d", hc), bus.ram_we, 0);
      chk($sformatf("burst_ready_c%0d", hc + 1), bus.wr_ready, (hc + 1) != 29);
    end
    chk("burst_write_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("burst_order_%0d", i), got_q[i], exp_q[i]);

    // 17 pushes leave 5 queued at hc17; reset there must discard them.
    for (int hc = 0; hc <= 16; hc++) begin
      drive(hc, 20, 1'b1, 1'b0, 1'b1, 1'b1, 15'(200 + hc), 8'(8'h80 + hc));
      tick();
    end
    drive(17, 20, 1'b1, 1'b0, 1'b1, 1'b0, 15'd0, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ram_we", bus.ram_we, 0);
    chk("midrst_wr_ready", bus.wr_ready, 1);
    chk("midrst_hsync_out", bus.hsync_out, 1);
    for (int k = 0; k < 20; k++) begin
      drive(700, 500, 1'b0, 1'b1, 1'b1, 1'b0, 15'd0, 8'h00);
      tick();
      chk($sformatf("postrst_no_we_%0d", k), bus.ram_we, 0);
    end
    chk("postrst_wr_ready", bus.wr_ready, 1);

`ifdef VRAM_CLEAR_EN
    n = 0;
    bus.clr_color = 8'h07;
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    chk("clr_busy_set", bus.clr_busy, 1);
    for (int k = 0; k < 25000; k++) begin
      tick();
      if (bus.ram_we) n++;
      if (!bus.clr_busy) break;
    end
    chk("clr_busy_done", bus.clr_busy, 0);
    chk("clr_write_count", n, 19200);
    tick();
    chk("clr_rd_0", vram[0], 8'h07);
    chk("clr_rd_12345", vram[12345], 8'h07);
    chk("clr_rd_19199", vram[19199], 8'h07);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
